// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 to code-point decoder with valid/ready on both sides and an output FIFO.
// Optional macro UTF8_REPLACE_EN: error entries carry U+FFFD instead of the raw value.
module utf8_stream_decoder #(
    parameter int          DEPTH    = 4,
    parameter logic [20:0] MAX_CP   = 21'h10FFFF,
    parameter bit          CHK_SURR = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [20:0]                  out_cp,
    output logic [2:0]                   out_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [2:0] E_OK = 3'd0, E_INVALID = 3'd1, E_TRUNC = 3'd2,
                           E_OVERLONG = 3'd3, E_SURR = 3'd4, E_RANGE = 3'd5;

    typedef struct packed {
        logic [20:0] cp;
        logic [2:0]  err;
    } entry_t;

    typedef enum logic {IDLE, CONT} state_t;

    state_t      state, state_n;
    logic [1:0]  rem, rem_n, len, len_n;
    logic [20:0] acc, acc_n;
    logic        pend_cont;

    logic        xfer, is_cont, is_ascii, is_lead;
    logic [1:0]  lead_rem;
    logic [20:0] lead_acc;

    entry_t      e0, e1;
    logic        push0, push1;

    function automatic entry_t make_entry(input logic [20:0] cp, input logic [2:0] err);
        entry_t r;
`ifdef UTF8_REPLACE_EN
        r.cp = (err != E_OK) ? 21'h00FFFD : cp;
`else
        r.cp = cp;
`endif
        r.err = err;
        return r;
    endfunction

    function automatic logic [2:0] classify(input logic [20:0] v, input logic [1:0] l);
        logic [20:0] min_v;
        min_v = (l == 2'd3) ? 21'h10000 : (l == 2'd2) ? 21'h00800 : 21'h00080;
        if (v < min_v)                                    return E_OVERLONG;
        if (CHK_SURR && v >= 21'h0D800 && v <= 21'h0DFFF) return E_SURR;
        if (v > MAX_CP)                                   return E_RANGE;
        return E_OK;
    endfunction

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign xfer     = in_valid && in_ready;
    assign is_cont  = (in_data[7:6] == 2'b10);
    assign is_ascii = !in_data[7];
    assign is_lead  = (in_data >= 8'hC2) && (in_data <= 8'hF4);

    always_comb begin
        lead_rem = 2'd3;
        lead_acc = {18'd0, in_data[2:0]};
        if (in_data < 8'hE0) begin
            lead_rem = 2'd1;
            lead_acc = {16'd0, in_data[4:0]};
        end else if (in_data < 8'hF0) begin
            lead_rem = 2'd2;
            lead_acc = {17'd0, in_data[3:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            len   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            len   <= len_n;
            acc   <= acc_n;
        end
    end

    always_comb begin
        state_n   = state;
        rem_n     = rem;
        len_n     = len;
        acc_n     = acc;
        pend_cont = 1'b0;
        if (xfer) begin
            if (state == CONT && is_cont) begin
                acc_n   = {acc[14:0], in_data[5:0]};
                rem_n   = rem - 2'd1;
                state_n = (rem == 2'd1) ? IDLE : CONT;
            end else if (is_lead) begin
                state_n = CONT;
                rem_n   = lead_rem;
                len_n   = lead_rem;
                acc_n   = lead_acc;
            end else begin
                state_n = IDLE;
            end
            pend_cont = (state_n == CONT);
            // End of stream closes any open sequence; the TRUNC push comes from the output logic.
            if (in_last) state_n = IDLE;
        end
    end

    // Up to three candidate pushes, at most two live at once, packed in stream order.
    always_comb begin
        entry_t a, b, c;
        logic   va, vb, vc;
        a  = '0; b = '0; c = '0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        if (xfer) begin
            if (state == CONT) begin
                if (is_cont) begin
                    va = (rem == 2'd1);
                    a  = make_entry(acc_n, classify(acc_n, len));
                end else begin
                    va = 1'b1;
                    a  = make_entry(acc, E_TRUNC);
                end
            end
            if (!(state == CONT && is_cont) && !is_lead) begin
                vb = 1'b1;
                b  = make_entry({13'd0, in_data}, is_ascii ? E_OK : E_INVALID);
            end
            if (in_last && pend_cont) begin
                vc = 1'b1;
                c  = make_entry(acc_n, E_TRUNC);
            end
        end
        push0 = va || vb || vc;
        push1 = 1'b0;
        e0    = c;
        e1    = c;
        if (va) begin
            e0    = a;
            e1    = vb ? b : c;
            push1 = vb || vc;
        end else if (vb) begin
            e0    = b;
            push1 = vc;
        end
    end

    assign busy = (state == CONT);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt_n;
    logic            rdy_q, pop;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign cnt_n     = count + CW'(push0) + CW'(push1) - CW'(pop);
    assign in_ready  = rdy_q && !rst;
    assign out_cp    = out_valid ? mem[rptr].cp  : '0;
    assign out_err   = out_valid ? mem[rptr].err : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdy_q <= 1'b1;
        end else begin
            count <= cnt_n;
            rdy_q <= (int'(DEPTH) - int'(cnt_n)) >= 2;
            if (pop) rptr <= inc(rptr);
            if (push1)      wptr <= inc(inc(wptr));
            else if (push0) wptr <= inc(wptr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push0) mem[wptr]      <= e0;
            if (push1) mem[inc(wptr)] <= e1;
        end
    end
endmodule

// File: doc/utf8_stream_decoder.md
Name: utf8_stream_decoder

Overview:
- Streaming UTF-8 to code-point decoder with valid/ready handshakes on both sides and a parametrised output FIFO.
- Successor to the single-character multiplexed-pin decoder. Adds back-pressure, buffering, end-of-stream truncation handling and a configurable range limit.
- Sits between a byte source (serial/bus interface) and a code-point consumer in the text-processing datapath.

Parameters:
- DEPTH, 4, output FIFO entries; legal values 2..16.
- MAX_CP, 21'h10FFFF, largest code point accepted without a RANGE error.
- CHK_SURR, 1, when 1 decoded U+D800..U+DFFF is flagged SURROGATE; when 0 it passes as OK.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  input byte
- in_valid  in  1  in_data valid
- in_last  in  1  byte is last of stream; qualified by in_valid
- in_ready  out  1  decoder accepts byte this cycle
- out_cp  out  21  code point at FIFO head
- out_err  out  3  error code at FIFO head: 0 OK, 1 INVALID, 2 TRUNC, 3 OVERLONG, 4 SURROGATE, 5 RANGE
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops head this cycle
- busy  out  1  partial multi-byte sequence held
- count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset state:
  - FIFO empty; out_valid=0, out_cp=0, out_err=0, count=0, busy=0.
  - in_ready=1 in the first cycle after rst deasserts; in_ready=0 while rst=1.
  - Reset mid-sequence discards the partial sequence without pushing an entry.
- Byte transfer: occurs on in_valid && in_ready.
- Pop: occurs on out_valid && out_ready.
- Push and pop in the same cycle are both permitted; count reflects both.
- in_ready = (DEPTH - count >= 2), registered from the next-state count. A transfer pushes at most 2 entries, so overflow is impossible.
- FSM states: IDLE; CONT with a 2-bit remaining counter (1..3), a 2-bit length register and a 21-bit accumulator.
- IDLE, by byte value:
  - 00-7F: push {byte, OK}.
  - C2-DF: CONT, rem=1.
  - E0-EF: CONT, rem=2.
  - F0-F4: CONT, rem=3.
  - 80-BF, C0, C1, F5-FF: push {byte, INVALID}, stay IDLE.
- CONT, byte 80-BF: shift 6 bits into the accumulator and decrement rem. At rem reaching 0, classify and push, then go to IDLE. Classification priority is OVERLONG > SURROGATE > RANGE > OK:
  - OVERLONG: value below the minimum for the length (0x800 for 3 bytes, 0x10000 for 4 bytes).
  - SURROGATE: value in D800-DFFF and CHK_SURR=1.
  - RANGE: value > MAX_CP.
- CONT, any non-continuation byte:
  - Push {accumulator, TRUNC}.
  - Re-process the byte as in IDLE in the same cycle, which may be a second push; the TRUNC entry is ordered first.
- in_last on an accepted byte:
  - If the FSM would remain in CONT after that byte, additionally push {accumulator, TRUNC} and return to IDLE.
  - Still at most 2 pushes per cycle.
- Latency: the entry completed by a byte accepted in cycle N is visible on out_* in cycle N+1 when the FIFO was empty. There is no bypass.
- out_cp, out_err and out_valid are FIFO-head registers and are stable while out_valid && !out_ready.
- busy = (state==CONT).
- FIFO: circular buffer with wrap-around read/write pointers. The full and empty conditions are derived from count.

Optional Feature:
- Macro: UTF8_REPLACE_EN.
- Defined: every entry with out_err != 0 carries out_cp = 21'h00FFFD; out_err is still reported.
- Undefined: error entries carry the raw value (offending byte for INVALID, partial accumulator for TRUNC, decoded value otherwise).

Test Plan:
- Back-to-back valid bytes 41, C3 A9, E2 82 AC, F0 9F 98 80 with out_ready=1 -> out_cp 0x41, 0xE9, 0x20AC, 0x1F600 in order, all out_err=0; first out_valid the cycle after the 41 transfer.
- Bytes C0, 80, F8 -> three INVALID entries: out_cp 0xC0, 0x80, 0xF8.
- Bytes E2 82 41 -> {0x0082, TRUNC} then {0x41, OK}, both pushed in the same cycle; count increases by 2.
- Bytes E0 80 80 -> {0x000, OVERLONG}. Bytes ED A0 80 -> {0xD800, SURROGATE}. With MAX_CP=0xFFFF, bytes F0 90 80 80 -> {0x10000, RANGE}.
- Byte F0 with in_last=1 -> single {0x0, TRUNC} entry; busy=0 the next cycle.
- DEPTH=4, out_ready=0, stream of 41s -> in_ready drops when count=3; no entry is lost. Releasing out_ready drains in order. Asserting rst after byte E2 -> count=0, busy=0, and no entry appears afterward.
